// File: rtl/dc_pkg.sv
// Shared sizing and FSM encoding for the data-cache miss controller.
package dc_pkg;
  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;
  localparam int IDX_W  = 2;
  localparam int TAG_W  = ADDR_W - IDX_W - 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_RD   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_e;
endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/dc_miss_ctrl.sv
// Blocking miss handler: optional dirty-victim writeback, line read, single-cycle
// fill, then a done pulse telling the C stage its op now hits.
module dc_miss_ctrl #(
  parameter int ADDR_W = dc_pkg::ADDR_W,
  parameter int LINE_W = dc_pkg::LINE_W,
  parameter int IDX_W  = dc_pkg::IDX_W,
  parameter int TAG_W  = ADDR_W - IDX_W - 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              c_valid_i,
  input  logic              c_miss_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [1:0]        c_lru_way_i,
  input  logic              c_victim_dirty_i,
  input  logic [TAG_W-1:0]  c_victim_tag_i,
  input  logic [LINE_W-1:0] c_victim_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic              fill_en_o,
  output logic [1:0]        fill_way_o,
  output logic [IDX_W-1:0]  fill_index_o,
  output logic [TAG_W-1:0]  fill_tag_o,
  output logic [LINE_W-1:0] fill_data_o,
  output logic              stall_core_o,
  output logic              miss_done_o,
  output logic [1:0]        miss_done_way_o,
  output logic [31:0]       miss_cnt_o,
  output logic [31:0]       wb_cnt_o
);
  import dc_pkg::*;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          way_q, way_d;
  logic [TAG_W-1:0]    vtag_q, vtag_d;
  logic [LINE_W-1:0]   vdata_q, vdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                killed_q, killed_d;
  logic                accept, wb_inc;
  logic [IDX_W-1:0]    idx;

  assign idx    = addr_q[IDX_W+3:4];
  // Reset outranks a same-cycle miss so no stall or count leaks through.
  assign accept = (state_q == S_IDLE) && c_valid_i && c_miss_i && !kill_i && !rst_i;
  assign wb_inc = (state_q == S_WB) && mem_ack_i;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    way_d           = way_q;
    vtag_d          = vtag_q;
    vdata_d         = vdata_q;
    rdata_d         = rdata_q;
    killed_d        = killed_q;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    fill_en_o       = 1'b0;
    fill_way_o      = '0;
    fill_index_o    = '0;
    fill_tag_o      = '0;
    fill_data_o     = '0;
    stall_core_o    = 1'b0;
    miss_done_o     = 1'b0;
    miss_done_way_o = '0;
    if (state_q != S_IDLE && kill_i) killed_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stall_core_o = 1'b1;
          addr_d       = c_addr_i;
          way_d        = c_lru_way_i;
          vtag_d       = c_victim_tag_i;
          vdata_d      = c_victim_data_i;
          killed_d     = 1'b0;
          state_d      = c_victim_dirty_i ? S_WB : S_RD;
        end
      end
      S_WB: begin
        stall_core_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b1;
        mem_addr_o   = {vtag_q, idx, 4'b0};
        mem_wdata_o  = vdata_q;
        if (mem_ack_i) state_d = S_RD;
      end
      S_RD: begin
        stall_core_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_addr_o   = {addr_q[ADDR_W-1:4], 4'b0};
        if (mem_ack_i) begin
          rdata_d = mem_rdata_i;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        stall_core_o = 1'b1;
        fill_en_o    = 1'b1;
        fill_way_o   = way_q;
        fill_index_o = idx;
        fill_tag_o   = addr_q[ADDR_W-1:IDX_W+4];
        fill_data_o  = rdata_q;
        state_d      = S_DONE;
      end
      S_DONE: begin
        miss_done_o     = !(killed_q || kill_i);
        miss_done_way_o = miss_done_o ? way_q : 2'd0;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      way_q    <= '0;
      vtag_q   <= '0;
      vdata_q  <= '0;
      rdata_q  <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      way_q    <= way_d;
      vtag_q   <= vtag_d;
      vdata_q  <= vdata_d;
      rdata_q  <= rdata_d;
      killed_q <= killed_d;
    end
  end

  sat_counter #(.W(32)) u_miss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (accept),
    .cnt_o (miss_cnt_o)
  );

  sat_counter #(.W(32)) u_wb_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wb_inc),
    .cnt_o (wb_cnt_o)
  );
endmodule

// File: tb/tb_dc_miss_ctrl.sv
// Scoreboard bench for dc_miss_ctrl: expected memory, fill and done events are
// queued when a miss is launched and popped as the DUT produces them.
module tb_dc_miss_ctrl;
  logic         clk = 1'b0;
  logic         rst_i, c_valid_i, c_miss_i, kill_i, c_victim_dirty_i, mem_ack_i;
  logic [19:0]  c_addr_i;
  logic [1:0]   c_lru_way_i;
  logic [13:0]  c_victim_tag_i;
  logic [127:0] c_victim_data_i, mem_rdata_i;
  logic         mem_req_o, mem_we_o, fill_en_o, stall_core_o, miss_done_o;
  logic [19:0]  mem_addr_o;
  logic [127:0] mem_wdata_o, fill_data_o;
  logic [1:0]   fill_way_o, fill_index_o, miss_done_way_o;
  logic [13:0]  fill_tag_o;
  logic [31:0]  miss_cnt_o, wb_cnt_o;

  typedef struct { logic we; logic [19:0] addr; logic [127:0] data; } mem_t;
  typedef struct { logic [1:0] way; logic [1:0] idx; logic [13:0] tag; logic [127:0] data; } fill_t;
  mem_t       mem_q[$];
  fill_t      fill_q[$];
  logic [1:0] done_q[$];
  int errors = 0, checks = 0;
  int exp_miss = 0, exp_wb = 0;

  always #5 clk = ~clk;

  dc_miss_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .c_valid_i(c_valid_i), .c_miss_i(c_miss_i), .kill_i(kill_i),
    .c_addr_i(c_addr_i), .c_lru_way_i(c_lru_way_i), .c_victim_dirty_i(c_victim_dirty_i),
    .c_victim_tag_i(c_victim_tag_i), .c_victim_data_i(c_victim_data_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .fill_en_o(fill_en_o), .fill_way_o(fill_way_o),
    .fill_index_o(fill_index_o), .fill_tag_o(fill_tag_o), .fill_data_o(fill_data_o),
    .stall_core_o(stall_core_o), .miss_done_o(miss_done_o), .miss_done_way_o(miss_done_way_o),
    .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
  );

  // Scoreboard monitor: every completed memory txn, fill and done pulse is popped and compared.
  always @(negedge clk) begin
    mem_t em; fill_t ef; logic [1:0] ed;
    if (mem_req_o && mem_ack_i) begin
      checks++;
      if (mem_q.size() == 0) begin
        errors++; $display("FAIL mem_txn: unexpected we=%0b addr=%h", mem_we_o, mem_addr_o);
      end else begin
        em = mem_q.pop_front();
        if (mem_we_o !== em.we || mem_addr_o !== em.addr || mem_wdata_o !== em.data) begin
          errors++;
          $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                   mem_we_o, mem_addr_o, mem_wdata_o, em.we, em.addr, em.data);
        end
      end
    end
    if (fill_en_o) begin
      checks++;
      if (fill_q.size() == 0) begin
        errors++; $display("FAIL fill: unexpected fill way=%0d", fill_way_o);
      end else begin
        ef = fill_q.pop_front();
        if (fill_way_o !== ef.way || fill_index_o !== ef.idx || fill_tag_o !== ef.tag || fill_data_o !== ef.data) begin
          errors++;
          $display("FAIL fill: got way=%0d idx=%0d tag=%h data=%h, want way=%0d idx=%0d tag=%h data=%h",
                   fill_way_o, fill_index_o, fill_tag_o, fill_data_o, ef.way, ef.idx, ef.tag, ef.data);
        end
      end
    end
    if (miss_done_o) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++; $display("FAIL done: unexpected miss_done way=%0d", miss_done_way_o);
      end else begin
        ed = done_q.pop_front();
        if (miss_done_way_o !== ed) begin
          errors++; $display("FAIL done: got way=%0d want way=%0d", miss_done_way_o, ed);
        end
      end
    end
  end

  task automatic mem_phase(input int dly, input logic [127:0] rd);
    logic [19:0] a0;
    a0 = mem_addr_o;
    repeat (dly) begin
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b1 || stall_core_o !== 1'b1 || fill_en_o !== 1'b0 || mem_addr_o !== a0) begin
        errors++;
        $display("FAIL hold: req=%0b stall=%0b fill=%0b addr=%h, want 1 1 0 %h",
                 mem_req_o, stall_core_o, fill_en_o, mem_addr_o, a0);
      end
      @(posedge clk); #1;
      kill_i = 1'b0;
    end
    mem_ack_i = 1'b1; mem_rdata_i = rd;
    @(posedge clk); #1;
    mem_ack_i = 1'b0; mem_rdata_i = '0; kill_i = 1'b0;
  endtask

  task automatic miss(input logic [19:0] a, input logic [1:0] w, input logic dirty, input logic [13:0] vt,
                      input logic [127:0] vd, input logic [127:0] rd, input int dly,
                      input logic kill_rd, input logic poke_done);
    mem_t m; fill_t f;
    if (dirty) begin
      m.we = 1'b1; m.addr = {vt, a[5:4], 4'h0}; m.data = vd; mem_q.push_back(m);
      exp_wb++;
    end
    m.we = 1'b0; m.addr = {a[19:4], 4'h0}; m.data = '0; mem_q.push_back(m);
    f.way = w; f.idx = a[5:4]; f.tag = a[19:6]; f.data = rd; fill_q.push_back(f);
    if (!kill_rd) done_q.push_back(w);
    exp_miss++;
    c_valid_i = 1'b1; c_miss_i = 1'b1; c_addr_i = a; c_lru_way_i = w;
    c_victim_dirty_i = dirty; c_victim_tag_i = vt; c_victim_data_i = vd;
    @(negedge clk);
    checks++;
    if (stall_core_o !== 1'b1) begin errors++; $display("FAIL accept_stall: got %0b want 1", stall_core_o); end
    @(posedge clk); #1;
    c_valid_i = 1'b0; c_miss_i = 1'b0;
    if (dirty) mem_phase(dly, '0);
    kill_i = kill_rd;
    mem_phase(dly, rd);
    @(negedge clk);
    checks++;
    if (fill_en_o !== 1'b1 || stall_core_o !== 1'b1) begin
      errors++; $display("FAIL fill_timing: fill_en=%0b stall=%0b want 1 1", fill_en_o, stall_core_o);
    end
    @(posedge clk); #1;
    if (poke_done) begin c_valid_i = 1'b1; c_miss_i = 1'b1; c_victim_dirty_i = 1'b0; end
    @(negedge clk);
    checks++;
    if (miss_done_o !== !kill_rd || stall_core_o !== 1'b0) begin
      errors++; $display("FAIL done_cycle: done=%0b stall=%0b want %0b 0", miss_done_o, stall_core_o, !kill_rd);
    end
    @(posedge clk); #1;
    if (poke_done) begin
      c_valid_i = 1'b0; c_miss_i = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b0 || stall_core_o !== 1'b0 || miss_cnt_o !== exp_miss) begin
        errors++; $display("FAIL done_no_accept: req=%0b stall=%0b cnt=%0d want 0 0 %0d",
                           mem_req_o, stall_core_o, miss_cnt_o, exp_miss);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (miss_cnt_o !== exp_miss || wb_cnt_o !== exp_wb) begin
      errors++; $display("FAIL %s: miss_cnt=%h wb_cnt=%h want %h %h", tag, miss_cnt_o, wb_cnt_o, exp_miss, exp_wb);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; c_valid_i = 0; c_miss_i = 0; kill_i = 0; mem_ack_i = 0; c_addr_i = '0;
    c_lru_way_i = '0; c_victim_dirty_i = 0; c_victim_tag_i = '0; c_victim_data_i = '0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 0 || stall_core_o !== 0 || fill_en_o !== 0 || miss_done_o !== 0 ||
        miss_cnt_o !== 0 || wb_cnt_o !== 0 || mem_addr_o !== 0) begin
      errors++; $display("FAIL reset: req=%0b stall=%0b fill=%0b done=%0b mc=%0d wc=%0d want all 0",
                         mem_req_o, stall_core_o, fill_en_o, miss_done_o, miss_cnt_o, wb_cnt_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_miss = 0; exp_wb = 0;
  endtask

  task automatic test_clean_miss();
    miss(20'h01234, 2'd2, 1'b0, 14'h0, '0, {4{32'hCAFE_0001}}, 3, 1'b0, 1'b0);
    check_counts("clean_counts");
  endtask

  task automatic test_dirty_miss();
    miss(20'h55550, 2'd1, 1'b1, 14'h0ABC, {4{32'hDEAD_BEEF}}, {4{32'h1234_5678}}, 2, 1'b0, 1'b0);
    check_counts("dirty_counts");
  endtask

  task automatic test_long_stall();
    miss(20'hABCD8, 2'd0, 1'b0, 14'h0, '0, {4{32'h0BAD_F00D}}, 10, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      miss(20'($urandom), 2'($urandom), 1'($urandom), 14'($urandom),
           {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           int'($urandom_range(0, 3)), 1'b0, (i == 2));
    check_counts("b2b_counts");
  endtask

  task automatic test_kill();
    miss(20'h3C3C0, 2'd3, 1'b0, 14'h0, '0, {4{32'h7777_8888}}, 1, 1'b1, 1'b0);
    c_valid_i = 1; c_miss_i = 1; kill_i = 1; c_addr_i = 20'h11110; c_victim_dirty_i = 1;
    @(negedge clk);
    checks++;
    if (stall_core_o !== 1'b0) begin errors++; $display("FAIL kill_accept_stall: got %0b want 0", stall_core_o); end
    @(posedge clk); #1;
    c_valid_i = 0; c_miss_i = 0; kill_i = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b0) begin errors++; $display("FAIL kill_accept_req: got %0b want 0", mem_req_o); end
      @(posedge clk); #1;
    end
    check_counts("kill_counts");
  endtask

  task automatic test_reset_mid();
    c_valid_i = 1; c_miss_i = 1; c_addr_i = 20'h24680; c_lru_way_i = 1;
    c_victim_dirty_i = 1; c_victim_tag_i = 14'h1111; c_victim_data_i = {4{32'h5555_AAAA}};
    @(posedge clk); #1;
    c_valid_i = 0; c_miss_i = 0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin
      errors++; $display("FAIL wb_entry: req=%0b we=%0b want 1 1", mem_req_o, mem_we_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_miss = 0; exp_wb = 0;
    @(negedge clk);
    checks++;
    if (mem_req_o !== 0 || stall_core_o !== 0 || miss_cnt_o !== 0 || wb_cnt_o !== 0) begin
      errors++; $display("FAIL reset_mid: req=%0b stall=%0b mc=%0d wc=%0d want 0 0 0 0",
                         mem_req_o, stall_core_o, miss_cnt_o, wb_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    dut.u_miss_cnt.cnt_q = 32'hFFFF_FFFE;
    miss(20'h0F0F0, 2'd2, 1'b0, 14'h0, '0, {4{32'h4242_4242}}, 0, 1'b0, 1'b0);
    checks++;
    if (miss_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_reach: got %h want ffffffff", miss_cnt_o); end
    miss(20'h0F100, 2'd1, 1'b0, 14'h0, '0, {4{32'h2424_2424}}, 0, 1'b0, 1'b0);
    checks++;
    if (miss_cnt_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h want ffffffff", miss_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_long_stall();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    test_saturate();
    repeat (3) @(posedge clk);
    checks++;
    if (mem_q.size() != 0 || fill_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL drain: pending mem=%0d fill=%0d done=%0d want 0 0 0",
                         mem_q.size(), fill_q.size(), done_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dc_miss_ctrl.md
DC_MISS_CTRL -- requirements
Module: dc_miss_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 20, byte address width.
REQ-002 Parameter: LINE_W, default 128, cache line width in bits (16 bytes).
REQ-003 Parameter: IDX_W, default 2, set index width; tag width = ADDR_W-IDX_W-4 (14).
REQ-004 Port: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-006 Port: c_valid_i  in  1  C-stage holds a valid memory op.
REQ-007 Port: c_miss_i  in  1  C-stage op missed in tag lookup.
REQ-008 Port: kill_i  in  1  flush of C-stage op.
REQ-009 Port: c_addr_i  in  ADDR_W  request byte address.
REQ-010 Port: c_lru_way_i  in  2  victim way.
REQ-011 Port: c_victim_dirty_i  in  1  victim line dirty and valid.
REQ-012 Port: c_victim_tag_i  in  TAG_W  victim tag.
REQ-013 Port: c_victim_data_i  in  LINE_W  victim line data.
REQ-014 Port: mem_req_o / mem_we_o  out  1 / 1  memory request, write select.
REQ-015 Port: mem_addr_o  out  ADDR_W  line-aligned memory address (low 4 bits zero).
REQ-016 Port: mem_wdata_o  out  LINE_W  writeback data.
REQ-017 Port: mem_ack_i  in  1  memory completes current request.
REQ-018 Port: mem_rdata_i  in  LINE_W  read data, valid in ack cycle.
REQ-019 Port: fill_en_o  out  1  write line into data/tag arrays, marks valid and clean.
REQ-020 Port: fill_way_o / fill_index_o / fill_tag_o / fill_data_o  out  2 / IDX_W / TAG_W / LINE_W  fill target and contents.
REQ-021 Port: stall_core_o  out  1  freeze pipeline, including TL->C latch.
REQ-022 Port: miss_done_o / miss_done_way_o  out  1 / 2  C-stage op now hits in given way.
REQ-023 Port: miss_cnt_o / wb_cnt_o  out  32 / 32  saturating perf counters.

Function
REQ-024 FSM states: IDLE, WB, RD, FILL, DONE.
REQ-025 IDLE: c_valid_i & c_miss_i & !kill_i accepts miss; latch addr, way, victim tag/data; go WB if dirty, else RD.
REQ-026 stall_core_o = 1 in WB, RD, FILL, and combinationally in the IDLE accept cycle; 0 in IDLE otherwise and in DONE.
REQ-027 WB: mem_req_o=1, mem_we_o=1, mem_addr_o={victim_tag,index,4'b0}, mem_wdata_o=latched victim data; on mem_ack_i go RD.
REQ-028 RD: mem_req_o=1, mem_we_o=0, mem_addr_o={latched addr[ADDR_W-1:4],4'b0}; on mem_ack_i capture mem_rdata_i, go FILL.
REQ-029 Request fields remain stable while mem_req_o=1 and ack absent; mem_ack_i with mem_req_o=0 is ignored.
REQ-030 WB->RD: mem_req_o stays high continuously; the next cycle presents the read.
REQ-031 FILL: fill_en_o=1 for exactly one cycle with latched way/index/tag and captured data; go DONE.
REQ-032 DONE: miss_done_o=1 and miss_done_way_o=latched way unless op killed; go IDLE; no miss accepted in DONE.
REQ-033 kill_i after acceptance does not abort the memory transaction or fill; it sets a killed flag that suppresses miss_done_o.
REQ-034 Miss latency without writeback, ack in first RD cycle: accept cycle T, RD T+1, FILL T+2, DONE T+3.
REQ-035 miss_cnt_o increments on each accept; wb_cnt_o increments on each WB ack; both saturate at 32'hFFFF_FFFF.
REQ-036 Outputs not driven by the current state are 0.

Reset
REQ-037 rst_i=1 at a clock edge: state IDLE, killed flag 0, counters 0, all outputs 0; effective mid-operation, in-flight request dropped.
REQ-038 Reset has priority over all other inputs.

Structure
REQ-039 Shared package dc_pkg holds ADDR_W, LINE_W, IDX_W, TAG_W, and the FSM state encoding.
REQ-040 A single sub-module sat_counter (32-bit, inc, synchronous reset) is instantiated twice for the perf counters.

Verification
REQ-041 Clean miss addr 20'h01234, way 2, ack after 3 cycles -> one RD at 20'h01230, fill_en_o one cycle with way 2, index 3, miss_done_o, miss_cnt_o=1.
REQ-042 Dirty miss, victim tag 14'h0ABC, index 1 -> WB at 20'h2AF10 with victim data, then RD, wb_cnt_o=1, stall held throughout.
REQ-043 Hold mem_ack_i low 10 cycles -> mem_req_o and mem_addr_o stable, stall_core_o high, no fill.
REQ-044 kill_i pulsed in RD -> fill still occurs, miss_done_o stays 0; kill_i in accept cycle -> no request at all.
REQ-045 rst_i asserted in WB -> next cycle mem_req_o=0, stall_core_o=0, counters 0, state IDLE.
REQ-046 Preload miss_cnt_o to 32'hFFFF_FFFF, one more miss -> remains 32'hFFFF_FFFF.
